// File: rtl/im_port_arbiter_if.sv
// Read-port bundle between the fetch stage, the debug readback port,
// the instruction-memory array and the arbiter that shares them.
// The arbiter uses the slave view. The requesters and the IM array use the master view.
interface im_port_arbiter_if #(
  parameter int IDX_W = 10
);
  logic             fetch_req;
  logic [31:0]      fetch_addr;
  logic             fetch_gnt;
  logic             fetch_rvalid;
  logic             dbg_req;
  logic [31:0]      dbg_addr;
  logic             dbg_gnt;
  logic             dbg_rvalid;
  logic [31:0]      rdata;
  logic             rerr;
  logic [IDX_W-1:0] im_index;
  logic [31:0]      im_instr;

  modport slave (
    input  fetch_req, fetch_addr, dbg_req, dbg_addr, im_instr,
    output fetch_gnt, fetch_rvalid, dbg_gnt, dbg_rvalid, rdata, rerr, im_index
  );

  modport master (
    output fetch_req, fetch_addr, dbg_req, dbg_addr, im_instr,
    input  fetch_gnt, fetch_rvalid, dbg_gnt, dbg_rvalid, rdata, rerr, im_index
  );
endinterface

// File: rtl/im_port_arbiter.sv
// Instruction-memory read-port arbiter. Fetch has fixed priority over debug.
// A starvation counter forces a debug grant after STARVE_LIMIT denied cycles.
// The granted byte address is turned into a word index for the IM array.
// The read data or an error flag is registered and returned one cycle later.
// Optional macro IM_ARB_PERF_CNT_EN adds the grant performance counters.
module im_port_arbiter #(
  parameter int          IM_WORDS     = 1024,
  parameter int          IDX_W        = 10,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_3000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  im_port_arbiter_if.slave   bus
`ifdef IM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_dbg_cnt,
  output logic [15:0]        perf_force_cnt
`endif
);

  localparam logic [29:0] WORDS_LIM = 30'(IM_WORDS);
  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);

  logic        dbg_gnt_next;
  logic        fetch_gnt_next;
  logic [31:0] sel_addr;
  logic [31:0] off;
  logic        misaligned;
  logic        oob;
  logic        acc_err;
  logic        unused_off_lsb;

  logic [3:0]  starve_cnt_reg;
  logic [31:0] rdata_reg;
  logic        rerr_reg;
  logic        fetch_rvalid_reg;
  logic        dbg_rvalid_reg;

  // Grant selection. Grants are held low while reset is asserted.
  // With no grant active, the fetch address drives the decode,
  // so the IM output stays stable for fetch.
  always_comb begin
    dbg_gnt_next   = reset_n & bus.dbg_req & (~bus.fetch_req | (starve_cnt_reg >= LIMIT));
    fetch_gnt_next = reset_n & bus.fetch_req & ~dbg_gnt_next;
    sel_addr       = dbg_gnt_next ? bus.dbg_addr : bus.fetch_addr;
    off            = sel_addr - ADDR_BASE;
    misaligned     = (sel_addr[1:0] != 2'b00);
    oob            = (sel_addr < ADDR_BASE) | (off[31:2] >= WORDS_LIM);
    acc_err        = misaligned | oob;
  end

  // The low offset bits are not used, because alignment is checked on the raw address.
  assign unused_off_lsb = ^off[1:0];

  assign bus.fetch_gnt    = fetch_gnt_next;
  assign bus.dbg_gnt      = dbg_gnt_next;
  assign bus.im_index     = off[IDX_W+1:2];
  assign bus.rdata        = rdata_reg;
  assign bus.rerr         = rerr_reg;
  assign bus.fetch_rvalid = fetch_rvalid_reg;
  assign bus.dbg_rvalid   = dbg_rvalid_reg;

  // Starvation counter. It counts consecutive denied debug cycles and saturates at 15.
  // It clears on a debug grant or when debug stops requesting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_reg <= 4'd0;
    end else if (bus.dbg_req && !dbg_gnt_next) begin
      if (starve_cnt_reg != 4'hF) starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end else begin
      starve_cnt_reg <= 4'd0;
    end
  end

  // One-cycle read response for whichever requester was granted.
  // Data and error flag hold their value when no grant is active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_reg        <= 32'd0;
      rerr_reg         <= 1'b0;
      fetch_rvalid_reg <= 1'b0;
      dbg_rvalid_reg   <= 1'b0;
    end else begin
      fetch_rvalid_reg <= fetch_gnt_next;
      dbg_rvalid_reg   <= dbg_gnt_next;
      if (fetch_gnt_next || dbg_gnt_next) begin
        rerr_reg  <= acc_err;
        rdata_reg <= acc_err ? 32'd0 : bus.im_instr;
      end
    end
  end

`ifdef IM_ARB_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_reg;
  logic [31:0] perf_dbg_cnt_reg;
  logic [15:0] perf_force_cnt_reg;

  // Grant statistics. These are free-running wrap-around counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt_reg <= 32'd0;
      perf_dbg_cnt_reg   <= 32'd0;
      perf_force_cnt_reg <= 16'd0;
    end else begin
      if (fetch_gnt_next) perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
      if (dbg_gnt_next)   perf_dbg_cnt_reg   <= perf_dbg_cnt_reg + 32'd1;
      if (dbg_gnt_next && bus.fetch_req) perf_force_cnt_reg <= perf_force_cnt_reg + 16'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_dbg_cnt   = perf_dbg_cnt_reg;
  assign perf_force_cnt = perf_force_cnt_reg;
`endif

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter. It uses a vector table, plus sequences for reset and perf counters.
module tb_im_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  im_port_arbiter_if #(.IDX_W(10)) bus ();

  logic [31:0] mem [1024];

`ifdef IM_ARB_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_dbg_cnt;
  logic [15:0] perf_force_cnt;
`endif

  im_port_arbiter #(
    .IM_WORDS(1024), .IDX_W(10), .ADDR_BASE(32'h0000_3000), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
`ifdef IM_ARB_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_dbg_cnt(perf_dbg_cnt),
    .perf_force_cnt(perf_force_cnt)
`endif
  );

  // Combinational instruction-memory model
  assign bus.im_instr = mem[bus.im_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        dr;
    logic [31:0] da;
    logic        efg;
    logic        edg;
    logic        efrv;
    logic        edrv;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

    //           fr   fa            dr   da            fg   dg   frv  drv  rdata          rerr
    vecs[0]  = '{1'b1, 32'h3000, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h3004, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 1'b0};
    vecs[2]  = '{1'b1, 32'h3008, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0002, 1'b0};
    vecs[3]  = '{1'b1, 32'h3002, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h2FFC, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h4000, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h3FFC, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_03FF, 1'b0};
    vecs[7]  = '{1'b0, 32'h3000, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_03FF, 1'b0};
    vecs[8]  = '{1'b0, 32'h3000, 1'b1, 32'h3020, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0008, 1'b0};
    for (int i = 9; i < 13; i++)
      vecs[i] = '{1'b1, 32'h3000, 1'b1, 32'h3010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 1'b0};
    vecs[13] = '{1'b1, 32'h3000, 1'b1, 32'h3010, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0004, 1'b0};
    vecs[14] = '{1'b1, 32'h3004, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 1'b0};
    vecs[15] = '{1'b1, 32'h3008, 1'b1, 32'h3FFC, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0002, 1'b0};
    vecs[16] = '{1'b1, 32'h3008, 1'b0, 32'h3FFC, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0002, 1'b0};
    for (int i = 17; i < 21; i++)
      vecs[i] = '{1'b1, 32'h300C, 1'b1, 32'h3FFC, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0003, 1'b0};
    vecs[21] = '{1'b1, 32'h300C, 1'b1, 32'h3FFC, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_03FF, 1'b0};
    vecs[22] = '{1'b0, 32'h300C, 1'b1, 32'h3001, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1};
    vecs[23] = '{1'b1, 32'h3000, 1'b1, 32'h5000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 1'b0};

    // Reset state: grants are forced low even with both requests raised.
    reset_n        = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h3000;
    bus.dbg_req    = 1'b1;
    bus.dbg_addr   = 32'h3000;
    #2;
    check("rst fetch_gnt", bus.fetch_gnt, 0);
    check("rst dbg_gnt", bus.dbg_gnt, 0);
    check("rst fetch_rvalid", bus.fetch_rvalid, 0);
    check("rst dbg_rvalid", bus.dbg_rvalid, 0);
    check("rst rdata", bus.rdata, 0);
    check("rst rerr", bus.rerr, 0);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.fetch_req = 1'b0;
    bus.dbg_req   = 1'b0;

    // Vector table: the grant is checked mid-cycle, and the response after the next edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.fetch_req  = vecs[i].fr;
      bus.fetch_addr = vecs[i].fa;
      bus.dbg_req    = vecs[i].dr;
      bus.dbg_addr   = vecs[i].da;
      #1;
      check($sformatf("v%0d fetch_gnt", i), bus.fetch_gnt, vecs[i].efg);
      check($sformatf("v%0d dbg_gnt", i), bus.dbg_gnt, vecs[i].edg);
      @(posedge clk);
      #1;
      check($sformatf("v%0d fetch_rvalid", i), bus.fetch_rvalid, vecs[i].efrv);
      check($sformatf("v%0d dbg_rvalid", i), bus.dbg_rvalid, vecs[i].edrv);
      check($sformatf("v%0d rdata", i), bus.rdata, vecs[i].erd);
      check($sformatf("v%0d rerr", i), bus.rerr, vecs[i].eerr);
      $display("vec %0d fr=%0b fa=%h dr=%0b da=%h -> fg=%0b dg=%0b frv=%0b drv=%0b rdata=%h rerr=%0b",
               i, vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].da, bus.fetch_gnt, bus.dbg_gnt,
               bus.fetch_rvalid, bus.dbg_rvalid, bus.rdata, bus.rerr);
    end

    // Mid-cycle asynchronous reset while a response is visible and another grant is in flight.
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h3004;
    bus.dbg_req    = 1'b0;
    @(posedge clk);
    #1;
    check("pre-rst fetch_rvalid", bus.fetch_rvalid, 1);
    check("pre-rst rdata", bus.rdata, 32'h1000_0001);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst fetch_rvalid", bus.fetch_rvalid, 0);
    check("async rst rdata", bus.rdata, 0);
    check("async rst rerr", bus.rerr, 0);
    check("async rst fetch_gnt", bus.fetch_gnt, 0);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.fetch_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-rst%0d fetch_rvalid", k), bus.fetch_rvalid, 0);
      check($sformatf("post-rst%0d dbg_rvalid", k), bus.dbg_rvalid, 0);
      check($sformatf("post-rst%0d rdata", k), bus.rdata, 0);
    end
    $display("reset sequence done");

`ifdef IM_ARB_PERF_CNT_EN
    // Contention for 10 cycles: debug is forced through on the 5th and 10th cycles.
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h3000;
    bus.dbg_req    = 1'b1;
    bus.dbg_addr   = 32'h3010;
    repeat (10) @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.dbg_req   = 1'b0;
    #1;
    check("perf_fetch_cnt", perf_fetch_cnt, 8);
    check("perf_dbg_cnt", perf_dbg_cnt, 2);
    check("perf_force_cnt", {16'd0, perf_force_cnt}, 2);
    $display("perf fetch=%0d dbg=%0d force=%0d", perf_fetch_cnt, perf_dbg_cnt, perf_force_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/im_port_arbiter.md
Name: im_port_arbiter

Overview:
- Shares the single combinational read port of the instruction memory between two requesters: the CPU fetch stage (`fetch`) and the debug/loader readback port (`dbg`).
- Fetch has fixed priority; a starvation counter forces a debug grant after a bounded wait.
- Translates byte addresses to word indices and flags misaligned or out-of-range accesses.
- Returns registered read data with 1-cycle latency.
- Sits between the fetch stage, the debug unit and the IM array.

Parameters:
- IM_WORDS, 1024, depth of instruction memory in 32-bit words (power of two).
- IDX_W, 10, word-index width; must equal log2(IM_WORDS).
- ADDR_BASE, 32'h0000_3000, byte address mapped to word 0.
- STARVE_LIMIT, 4, maximum consecutive cycles dbg_req may be denied; range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- fetch_req  input  1  fetch read request
- fetch_addr  input  32  fetch byte address
- fetch_gnt  output  1  fetch request accepted this cycle (combinational)
- fetch_rvalid  output  1  response for fetch valid (registered)
- dbg_req  input  1  debug read request
- dbg_addr  input  32  debug byte address
- dbg_gnt  output  1  debug request accepted this cycle (combinational)
- dbg_rvalid  output  1  response for dbg valid (registered)
- rdata  output  32  shared response data
- rerr  output  1  response error (misaligned or out of range), qualified by either rvalid
- im_index  output  IDX_W  word index driven to the IM array
- im_instr  input  32  combinational IM read data for im_index

Behaviour:
- Reset (async, reset_n=0) clears all state and outputs to 0: rdata, rerr, fetch_rvalid, dbg_rvalid, starve_cnt, and the perf counters if present.
- While reset_n=0, fetch_gnt and dbg_gnt are forced to 0.
- Grant rule, combinational per cycle; at most one grant:
  - dbg_gnt = dbg_req & (~fetch_req | starve_cnt >= STARVE_LIMIT)
  - fetch_gnt = fetch_req & ~dbg_gnt
- starve_cnt, 4 bits:
  - increments when dbg_req=1 and dbg_gnt=0;
  - clears to 0 on a dbg grant or when dbg_req=0;
  - saturates at 15.
- A requester holds req/addr until it sees its gnt. Dropping req before gnt is legal and simply cancels the request.
- Address decode on the granted address A:
  - off = A - ADDR_BASE (32-bit wrap)
  - misaligned = A[1:0] != 0
  - oob = (A < ADDR_BASE) | (off[31:2] >= IM_WORDS)
  - im_index = off[IDX_W+1:2]
- When no grant is active, im_index = the index of fetch_addr (keeps IM output stable for fetch).
- Response, at the clock edge after a grant:
  - the matching rvalid = 1 for exactly one cycle;
  - rerr = misaligned | oob;
  - rdata = rerr ? 0 : im_instr.
- With no grant, both rvalid = 0 next cycle and rdata/rerr hold their last value.
- Back-to-back grants are allowed every cycle, giving full throughput, one response per cycle in grant order.
- Simultaneous requests below the limit: fetch wins. At the limit, dbg wins for one cycle, then the counter clears.
- Reset asserted mid-operation: any in-flight response is dropped, and no rvalid is seen after reset release until a new grant.

Optional Feature:
- Macro IM_ARB_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt[31:0], perf_dbg_cnt[31:0] and perf_force_cnt[15:0]:
  - perf_fetch_cnt counts fetch grants;
  - perf_dbg_cnt counts dbg grants;
  - perf_force_cnt counts dbg grants taken while fetch_req=1.
- All three wrap on overflow and reset to 0.
- When not defined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- IM preloaded with word[i]=32'h1000_0000+i. Fetch-only, fetch_addr=32'h3000, 32'h3004, 32'h3008 on consecutive cycles -> fetch_gnt=1 each cycle; fetch_rvalid one cycle later each, with rdata 32'h1000_0000, 32'h1000_0001, 32'h1000_0002 and rerr=0.
- Contention, fetch_req=1 held with dbg_req=1 at dbg_addr=32'h3010 -> dbg denied 4 cycles, dbg_gnt=1 on the 5th; dbg_rvalid next cycle with rdata=32'h1000_0004; the cycle after, fetch regains the grant.
- Errors:
  - fetch_addr=32'h3002 -> rerr=1, rdata=0.
  - fetch_addr=32'h2FFC -> rerr=1.
  - fetch_addr=32'h4000 (off=0x1000, index 1024) -> rerr=1.
  - fetch_addr=32'h3FFC -> rerr=0, rdata=32'h1000_03FF.
- dbg_req alone at 32'h3020 -> immediate dbg_gnt; dbg_rvalid=1, fetch_rvalid=0; starve_cnt stays 0.
- Assert reset_n=0 asynchronously mid-cycle, the cycle after a grant -> rvalid, rdata and rerr go to 0 immediately; no response appears after release.
- With IM_ARB_PERF_CNT_EN defined, run the contention scenario for 10 cycles -> perf_fetch_cnt=8, perf_dbg_cnt=2, perf_force_cnt=2.
